rr_accumulator: RTL and testbench
=================================

Name: rr_accumulator

Overview:
- Parametrised successor to the fixed 4-processor accumulator subsystem.
- NUM_CH producer channels each offer WIDTH-bit operands over a valid/ready handshake.
- A built-in round-robin arbiter selects one channel per cycle into a single shared adder. The running sum is accumulated until a programmed operand count is reached; the sum is then published as the result.
- Adds behaviour the previous generation lacked: programmable target count, optional saturation, sticky overflow, and restart without a full reset.

Parameters:
- NUM_CH, 4, number of producer channels (>=2).
- WIDTH, 32, operand and accumulator width in bits.
- CNT_W, 10, width of the operand counter and target.
- SAT_EN, 0, 1 = saturate accumulator at all-ones on carry-out; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; latches target and begins a run.
- target  input  CNT_W  number of operands to accumulate; sampled on start.
- req_valid  input  NUM_CH  per-channel operand valid.
- req_data  input  NUM_CH*WIDTH  per-channel operands; channel i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_CH  per-channel accept; at most one bit high.
- grant  output  NUM_CH  one-hot channel currently selected by the arbiter (0 when none).
- result  output  WIDTH  final sum when full=1, else 0.
- count  output  CNT_W  operands accepted in the current run.
- busy  output  1  high in RUN.
- full  output  1  high in DONE (run complete).
- overflow  output  1  sticky; set on any carry-out during the run.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; accumulator, count, overflow, stored target = 0.
  - Round-robin pointer = channel 0.
  - Outputs: req_ready=0, grant=0, result=0, busy=0, full=0.
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE:
  - start=1 clears accumulator, count and overflow, and latches target.
  - Next state is RUN, or DONE if target==0 (result then reads 0).
- RUN:
  - Arbitration is combinational. It searches req_valid starting at the pointer and wrapping modulo NUM_CH.
  - The first valid channel k gets grant=onehot(k) and req_ready=onehot(k). If no channel is valid, grant=0.
  - Transfer happens when req_valid[k]&req_ready[k]. On the next edge: accumulator += req_data[k], count += 1, pointer = (k+1) mod NUM_CH.
  - Pointer is unchanged on cycles with no transfer.
  - Throughput: one operand per cycle.
  - The transfer that makes count==target moves the block to DONE on the same edge. No further ready is asserted.
  - start is ignored in RUN.
- Arithmetic:
  - The addition is computed WIDTH+1 bits wide. A carry-out sets overflow (sticky until next start or reset).
  - SAT_EN=1: the accumulator becomes all-ones on carry-out and remains saturated for the rest of the run.
  - SAT_EN=0: the accumulator keeps the low WIDTH bits.
- DONE:
  - full=1 and result=accumulator, valid the cycle after the final transfer.
  - req_ready=0 and the state is held indefinitely.
  - start=1 restarts exactly as from IDLE, with the new target. full drops on the following cycle.
- Pointer persists across runs, so fairness carries over; only reset returns it to 0.
- Channel operands not accepted are the producer's responsibility to hold. The block never drops or duplicates an accepted operand.
- Reset asserted mid-run: all state cleared immediately, no partial result exposed.
- Outputs count and busy are registered-state derived. req_ready and grant are combinational from state, pointer and req_valid.

Decomposition:
- Package rr_acc_pkg holds:
  - the state enum/localparams (ST_IDLE, ST_RUN, ST_DONE);
  - a helper function for the one-hot-to-index conversion.
- Sub-module rr_arbiter_param (parameter NUM_CH):
  - inputs: req, pointer, enable;
  - outputs: one-hot grant and granted index.
  - Purely combinational; reused by future bus blocks.
- Top keeps the FSM, counter, accumulator and pointer register.

Test Plan:
1. Reset then start, target=4; all 4 channels valid with data 1,2,3,4 -> grants ch0,ch1,ch2,ch3 on consecutive cycles, count 1..4, full=1, result=10, overflow=0.
2. Fairness: ch1 and ch3 held valid, target=6 -> grants alternate ch1,ch3,ch1,ch3,ch1,ch3; next run's first grant is ch1 (pointer=0 search, ch0 invalid).
3. Gaps: single channel ch2 valid only on every other cycle, data 5, target=3 -> no grant on idle cycles, count reaches 3 after 5 cycles, result=15.
4. Overflow: WIDTH=32, SAT_EN=0, operands 0xFFFFFFFF and 0x00000002, target=2 -> result=0x00000001, overflow=1. Repeat with SAT_EN=1 -> result=0xFFFFFFFF, overflow=1.
5. Boundaries: start with target=0 -> full=1 next cycle, result=0. start during RUN -> ignored. reset=0 mid-run after 2 operands -> count=0, full=0, busy=0 immediately.
6. Restart: after DONE with result=10, start with target=1, ch0 data 7 -> full drops for one cycle, then full=1, result=7, overflow=0.

Source files
------------

// File: rtl/rr_acc_pkg.sv
// Shared types and helpers for the round-robin accumulator and its arbiter.
package rr_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest one-hot vector the index helper accepts.
  localparam int MAX_CH = 32;

  // Position of the set bit in a one-hot vector; 0 when the vector is empty.
  function automatic int oh_to_idx(input logic [MAX_CH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_param.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter_param
  import rr_acc_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  pointer,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx
);

  logic [PTR_W-1:0] scan;
  logic             found;

  // Walk the channels from the pointer, wrapping at NUM_CH, and stop at the first request.
  always_comb begin
    grant = '0;
    scan  = pointer;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable && !found && req[scan]) begin
        grant[scan] = 1'b1;
        found       = 1'b1;
      end
      scan = (scan == PTR_W'(NUM_CH - 1)) ? '0 : scan + PTR_W'(1);
    end
  end

  assign grant_idx = PTR_W'(oh_to_idx(MAX_CH'(grant)));

endmodule

// File: rtl/rr_accumulator.sv
// Round-robin multi-channel accumulator with programmable operand count.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | after reset; waiting for start
// ST_RUN  | accepting one operand per cycle until count reaches target
// ST_DONE | run complete; result published and held until next start
module rr_accumulator
  import rr_acc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 10,
  parameter int SAT_EN = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        target,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]       req_ready,
  output logic [NUM_CH-1:0]       grant,
  output logic [WIDTH-1:0]        result,
  output logic [CNT_W-1:0]        count,
  output logic                    busy,
  output logic                    full,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(NUM_CH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [NUM_CH-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH:0]    sum;
  logic              xfer;

  rr_arbiter_param #(.NUM_CH(NUM_CH)) u_arb (
    .req       (req_valid),
    .pointer   (ptr_q),
    .enable    (state_q == ST_RUN),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign grant     = gnt;
  assign req_ready = gnt;
  assign xfer      = |(gnt & req_valid);

  // Route the granted channel's operand to the shared adder.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // One extra bit captures the carry-out that feeds overflow and saturation.
  assign sum = {1'b0, acc_q} + {1'b0, sel_data};

  // Sequencing, accumulation and pointer advance.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    target_d = target_q;
    ovf_d    = ovf_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          acc_d    = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
          target_d = target;
          state_d  = (target == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          ovf_d   = ovf_q | sum[WIDTH];
          acc_d   = (SAT_EN != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
          count_d = count_q + CNT_W'(1);
          ptr_d   = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
          if (count_d == target_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything including the fairness pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      target_q <= '0;
      ovf_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      target_q <= target_d;
      ovf_q    <= ovf_d;
      ptr_q    <= ptr_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign full     = (state_q == ST_DONE);
  assign result   = full ? acc_q : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rr_accumulator.sv
// Scoreboard bench: driver feeds a reference model and queues expectations, monitor checks.
module tb_rr_accumulator;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int CNT_W  = 10;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic [CNT_W-1:0]        target;
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*WIDTH-1:0] req_data;

  logic [NUM_CH-1:0] ready_w, ready_s, grant_w, grant_s;
  logic [WIDTH-1:0]  result_w, result_s;
  logic [CNT_W-1:0]  count_w, count_s;
  logic              busy_w, busy_s, full_w, full_s, ovf_w, ovf_s;

  rr_accumulator #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W), .SAT_EN(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .req_valid(req_valid), .req_data(req_data), .req_ready(ready_w), .grant(grant_w),
    .result(result_w), .count(count_w), .busy(busy_w), .full(full_w), .overflow(ovf_w)
  );

  rr_accumulator #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W), .SAT_EN(1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .req_valid(req_valid), .req_data(req_data), .req_ready(ready_s), .grant(grant_s),
    .result(result_s), .count(count_s), .busy(busy_s), .full(full_s), .overflow(ovf_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NUM_CH-1:0] grant;
    logic              busy;
    logic              full;
    logic [CNT_W-1:0]  count;
  } cyc_t;

  typedef struct {
    logic [WIDTH-1:0] res_w;
    logic [WIDTH-1:0] res_s;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } res_t;

  cyc_t cyc_q[$];
  res_t res_q[$];
  logic [WIDTH-1:0] chq[NUM_CH][$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: run/done flags, operand count, pointer and two accumulators.
  bit m_run, m_done, m_ovf;
  int m_cnt, m_tgt, m_ptr;
  longint unsigned m_acc_w, m_acc_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_q();
    for (int c = 0; c < NUM_CH; c++) chq[c].delete();
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return WIDTH'($urandom_range(0, 1000));
  endfunction

  task automatic push_result();
    res_t r;
    r.res_w = WIDTH'(m_acc_w);
    r.res_s = WIDTH'(m_acc_s);
    r.ovf   = m_ovf;
    r.cnt   = CNT_W'(m_cnt);
    res_q.push_back(r);
  endtask

  // One clock cycle: drive inputs at the falling edge, queue what the DUT should show, advance model.
  task automatic cycle(input bit st, input int tg, input bit rst_lo, input logic [NUM_CH-1:0] gate);
    cyc_t e;
    logic [NUM_CH-1:0] v;
    int k;
    bit was_done;
    longint unsigned d, s;
    @(negedge clk);
    if (rst_lo) begin
      reset = 1'b0;
      start = 1'b0;
      req_valid = '0;
      m_run = 0; m_done = 0; m_ovf = 0;
      m_cnt = 0; m_tgt = 0; m_ptr = 0;
      m_acc_w = 0; m_acc_s = 0;
      e.grant = '0; e.busy = 1'b0; e.full = 1'b0; e.count = '0;
      cyc_q.push_back(e);
      return;
    end
    reset  = 1'b1;
    start  = st;
    target = CNT_W'(tg);
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v[c] = gate[c] && (chq[c].size() > 0);
      req_data[c*WIDTH +: WIDTH] = v[c] ? chq[c][0] : '0;
    end
    req_valid = v;
    k = -1;
    if (m_run) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (k < 0 && v[(m_ptr + i) % NUM_CH]) k = (m_ptr + i) % NUM_CH;
      end
    end
    e.grant = (k >= 0) ? NUM_CH'(1 << k) : '0;
    e.busy  = m_run;
    e.full  = m_done;
    e.count = CNT_W'(m_cnt);
    cyc_q.push_back(e);
    if (!m_run && st) begin
      was_done = m_done;
      m_acc_w = 0; m_acc_s = 0; m_cnt = 0; m_ovf = 0; m_tgt = tg;
      if (tg == 0) begin
        m_done = 1;
        if (!was_done) push_result();
      end else begin
        m_run = 1;
        m_done = 0;
      end
    end else if (m_run && k >= 0) begin
      d = longint'(chq[k].pop_front());
      s = m_acc_w + d;
      if (s >= MOD) begin m_ovf = 1; s = s - MOD; end
      m_acc_w = s;
      s = m_acc_s + d;
      m_acc_s = (s >= MOD) ? MOD - 1 : s;
      m_cnt++;
      m_ptr = (k + 1) % NUM_CH;
      if (m_cnt == m_tgt) begin
        m_run = 0;
        m_done = 1;
        push_result();
      end
    end
  endtask

  task automatic run_to_done(input int budget, input logic [NUM_CH-1:0] ga, input logic [NUM_CH-1:0] gb);
    int n;
    n = 0;
    while (m_run && n < budget) begin
      cycle(0, 0, 0, (n % 2 == 0) ? ga : gb);
      n++;
    end
    n_cmp++;
    if (m_run) begin
      n_bad++;
      $display("FAIL run_budget: still running after %0d cycles, required done", budget);
    end
  endtask

  // Monitor: checks every cycle's visible state and pops a result whenever full rises.
  initial begin
    cyc_t e;
    res_t r;
    logic prev_full;
    prev_full = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (cyc_q.size() == 0) begin
        chk("cyc_queue_nonempty", 64'(cyc_q.size()), 64'd1);
      end else begin
        e = cyc_q.pop_front();
        chk("grant_w", 64'(grant_w), 64'(e.grant));
        chk("grant_s", 64'(grant_s), 64'(e.grant));
        chk("ready_w", 64'(ready_w), 64'(e.grant));
        chk("ready_s", 64'(ready_s), 64'(e.grant));
        chk("busy_w", 64'(busy_w), 64'(e.busy));
        chk("busy_s", 64'(busy_s), 64'(e.busy));
        chk("full_w", 64'(full_w), 64'(e.full));
        chk("full_s", 64'(full_s), 64'(e.full));
        chk("count_w", 64'(count_w), 64'(e.count));
        chk("count_s", 64'(count_s), 64'(e.count));
      end
      if (!full_w) begin
        chk("result_w_idle", 64'(result_w), 64'd0);
        chk("result_s_idle", 64'(result_s), 64'd0);
      end
      if (full_w && !prev_full) begin
        if (res_q.size() == 0) begin
          chk("res_queue_nonempty", 64'(res_q.size()), 64'd1);
        end else begin
          r = res_q.pop_front();
          chk("result_wrap", 64'(result_w), 64'(r.res_w));
          chk("result_sat", 64'(result_s), 64'(r.res_s));
          chk("overflow_wrap", 64'(ovf_w), 64'(r.ovf));
          chk("overflow_sat", 64'(ovf_s), 64'(r.ovf));
          chk("final_count", 64'(count_w), 64'(r.cnt));
        end
      end
      prev_full = full_w;
    end
  end

  // Driver: directed scenarios followed by randomized runs.
  initial begin
    int tg;
    logic [NUM_CH-1:0] act;
    reset = 1'b0; start = 1'b0; target = '0; req_valid = '0; req_data = '0;
    m_run = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_tgt = 0; m_ptr = 0;
    m_acc_w = 0; m_acc_s = 0;

    repeat (3) cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);

    // Four channels, data 1..4: grants ch0..ch3 back to back, sum 10.
    clear_q();
    for (int c = 0; c < NUM_CH; c++) chq[c].push_back(WIDTH'(c + 1));
    cycle(1, 4, 0, 4'hF);
    run_to_done(20, 4'hF, 4'hF);
    cycle(0, 0, 0, 4'hF);

    // Restart straight from DONE with target 1.
    clear_q();
    chq[0].push_back(32'd7);
    cycle(1, 1, 0, 4'hF);
    run_to_done(20, 4'hF, 4'hF);
    cycle(0, 0, 0, 4'hF);

    // Fairness between ch1 and ch3, with a start pulse mid-run that must be ignored.
    clear_q();
    for (int j = 0; j < 10; j++) begin
      chq[1].push_back(rand_op());
      chq[3].push_back(rand_op());
    end
    cycle(1, 6, 0, 4'hF);
    cycle(0, 0, 0, 4'hF);
    cycle(0, 0, 0, 4'hF);
    cycle(1, 1, 0, 4'hF);
    run_to_done(20, 4'hF, 4'hF);
    cycle(0, 0, 0, 4'hF);
    cycle(1, 2, 0, 4'hF);
    run_to_done(20, 4'hF, 4'hF);

    // Single channel valid every other cycle.
    clear_q();
    repeat (3) chq[2].push_back(32'd5);
    cycle(1, 3, 0, 4'b0100);
    run_to_done(20, 4'b0100, 4'b0000);
    cycle(0, 0, 0, 4'hF);

    // Carry-out: wraps to 1 in one instance, saturates in the other.
    clear_q();
    chq[0].push_back(32'hFFFF_FFFF);
    chq[0].push_back(32'h0000_0002);
    cycle(1, 2, 0, 4'hF);
    run_to_done(20, 4'hF, 4'hF);
    cycle(0, 0, 0, 4'hF);

    // Reset mid-run after two operands, then a zero-length run from IDLE.
    clear_q();
    repeat (5) chq[0].push_back(rand_op());
    cycle(1, 5, 0, 4'hF);
    for (int n = 0; n < 10 && m_cnt < 2; n++) cycle(0, 0, 0, 4'hF);
    cycle(0, 0, 1, '0);
    cycle(0, 0, 0, 4'hF);
    cycle(1, 0, 0, 4'hF);
    cycle(0, 0, 0, 4'hF);
    cycle(0, 0, 0, 4'hF);

    // Randomized runs with random channel sets, gaps and operands.
    for (int r = 0; r < 25; r++) begin
      clear_q();
      tg  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      act = NUM_CH'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++) begin
        if (act[c]) begin
          for (int j = 0; j <= tg; j++) chq[c].push_back(rand_op());
        end
      end
      repeat ($urandom_range(0, 2)) cycle(0, 0, 0, NUM_CH'($urandom));
      cycle(1, tg, 0, NUM_CH'($urandom));
      for (int n = 0; n < 200 && m_run; n++) cycle(0, 0, 0, NUM_CH'($urandom));
      n_cmp++;
      if (m_run) begin
        n_bad++;
        $display("FAIL random_budget: run %0d still active, required done", r);
      end
    end
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    #4;
    chk("cyc_queue_drained", 64'(cyc_q.size()), 64'd0);
    chk("res_queue_drained", 64'(res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
